// File: rtl/prbs11_checker_pkg.sv
// Shared definitions for the PRBS11 checker: state encoding, default tap mask
// and statistics counter widths.
package prbs11_checker_pkg;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    FILL   = ST_FILL,
    VERIFY = ST_VERIFY,
    LOCKED = ST_LOCKED
  } state_e;

  // x^11+x^10+x^8+x^7+x^5+x^4+x^3+x+1 as a lag mask: bit k <=> lag k+1
  localparam logic [10:0] TAPS_DEG11 = 11'b11011101101;

  localparam int ERR_CNT_W = 16;
  localparam int BIT_CNT_W = 32;

endpackage

// File: rtl/prbs11_checker_predict.sv
// Combinational next-bit predictor: XOR of the history bits selected by the lag mask.
module prbs_predict
  import prbs11_checker_pkg::*;
#(
  parameter int                DEGREE = 11,
  parameter logic [DEGREE-1:0] TAPS   = TAPS_DEG11
) (
  input  logic [DEGREE-1:0] Hist_DI,
  output logic              Pred_DO
);

  assign Pred_DO = ^(Hist_DI & TAPS);

endmodule

// File: rtl/prbs11_checker.sv
// Self-synchronising PRBS checker: fills a history register from the received
// stream, verifies predictions to gain lock, then counts bit errors while locked.
module prbs11_checker
  import prbs11_checker_pkg::*;
#(
  parameter int                DEGREE      = 11,
  parameter logic [DEGREE-1:0] TAPS        = TAPS_DEG11,
  parameter int                LOCK_CNT    = 16,
  parameter int                WINDOW      = 64,
  parameter int                LOSS_THRESH = 8
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 BitValid_SI,
  input  logic                 Bit_DI,
  input  logic                 Clear_SI,
  output logic                 Locked_SO,
  output logic                 ErrPulse_SO,
  output logic [ERR_CNT_W-1:0] ErrCnt_DO,
  output logic [BIT_CNT_W-1:0] BitCnt_DO,
  output logic [1:0]           DbgState_DO
);

  // Handshake: Bit_DI is consumed on every rising edge where BitValid_SI is high;
  // there is no backpressure, and every register holds while BitValid_SI is low.

  localparam int FILL_W = $clog2(DEGREE + 1);
  localparam int VER_W  = $clog2(LOCK_CNT + 1);
  localparam int WBIT_W = $clog2(WINDOW + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEGREE - 1);
  localparam logic [VER_W-1:0]  VER_LAST  = VER_W'(LOCK_CNT - 1);
  localparam logic [WBIT_W-1:0] WBIT_LAST = WBIT_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THRESH - 1);

  state_e               r_state;
  logic [DEGREE-1:0]    r_hist;
  logic [FILL_W-1:0]    r_fill_cnt;
  logic [VER_W-1:0]     r_ver_cnt;
  logic [WBIT_W-1:0]    r_win_bits;
  logic [WERR_W-1:0]    r_win_errs;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;

  logic              w_pred;
  logic              w_mismatch;
  logic              w_checking;
  logic [DEGREE-1:0] w_hist_next;

  prbs_predict #(
    .DEGREE (DEGREE),
    .TAPS   (TAPS)
  ) u_predict (
    .Hist_DI (r_hist),
    .Pred_DO (w_pred)
  );

  assign w_mismatch  = Bit_DI ^ w_pred;
  assign w_hist_next = {r_hist[DEGREE-2:0], Bit_DI};
  assign w_checking  = BitValid_SI && (r_state == LOCKED);

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_state     <= FILL;
      r_hist      <= '0;
      r_fill_cnt  <= '0;
      r_ver_cnt   <= '0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (BitValid_SI) begin
        r_hist <= w_hist_next;
        unique case (r_state)
          FILL: begin
            if (r_fill_cnt == FILL_LAST) begin
              r_fill_cnt <= '0;
              // an all-zero history is the LFSR lock-up state, so fill again
              if (w_hist_next != '0) r_state <= VERIFY;
            end else begin
              r_fill_cnt <= r_fill_cnt + 1'b1;
            end
          end
          VERIFY: begin
            if (w_mismatch) begin
              r_state    <= FILL;
              r_fill_cnt <= '0;
              r_ver_cnt  <= '0;
            end else if (r_ver_cnt == VER_LAST) begin
              r_state    <= LOCKED;
              r_ver_cnt  <= '0;
              r_win_bits <= '0;
              r_win_errs <= '0;
            end else begin
              r_ver_cnt <= r_ver_cnt + 1'b1;
            end
          end
          LOCKED: begin
            r_err_pulse <= w_mismatch;
            if (w_mismatch && (r_win_errs == WERR_LAST)) begin
              r_state    <= FILL;
              r_fill_cnt <= '0;
              r_win_bits <= '0;
              r_win_errs <= '0;
            end else if (r_win_bits == WBIT_LAST) begin
              r_win_bits <= '0;
              r_win_errs <= '0;
            end else begin
              r_win_bits <= r_win_bits + 1'b1;
              r_win_errs <= r_win_errs + WERR_W'(w_mismatch);
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

  // Clear outranks a coincident count; lock state is untouched by it.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI || Clear_SI) begin
      r_err_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_checking) begin
      if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_mismatch && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign Locked_SO   = (r_state == LOCKED);
  assign ErrPulse_SO = r_err_pulse;
  assign ErrCnt_DO   = r_err_cnt;
  assign BitCnt_DO   = r_bit_cnt;
  assign DbgState_DO = r_state;

endmodule

// File: tb/tb_prbs11_checker.sv
// Directed bench for prbs11_checker: one instance with the default tap mask and
// one with the two-tap PRBS11 mask (lags 9 and 11) fed in lockstep.
module tb_prbs11_checker;

  localparam logic [10:0] TAPS_A = prbs11_checker_pkg::TAPS_DEG11;
  localparam logic [10:0] TAPS_B = 11'b10100000000;

  logic        clk;
  logic        rst, vld, clr, bit_a, bit_b;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] err_a, err_b;
  logic [31:0] bitc_a, bitc_b;
  logic [1:0]  state_a, state_b;

  logic [10:0] g_a, g_b, rx_a;
  int          n_checks, n_fail;

  typedef struct {
    logic        rst;
    logic        vld;
    logic        clr;
    logic        flip_b;
    logic        exp_locked;
    logic        exp_pulse_b;
    logic [15:0] exp_err_b;
    logic [31:0] exp_bit_a;
  } vec_t;

  vec_t tbl[17];

  prbs11_checker u_dut_a (
    .Clk_CI(clk), .Rst_RI(rst), .BitValid_SI(vld), .Bit_DI(bit_a), .Clear_SI(clr),
    .Locked_SO(locked_a), .ErrPulse_SO(pulse_a), .ErrCnt_DO(err_a), .BitCnt_DO(bitc_a),
    .DbgState_DO(state_a)
  );

  prbs11_checker #(.TAPS(TAPS_B)) u_dut_b (
    .Clk_CI(clk), .Rst_RI(rst), .BitValid_SI(vld), .Bit_DI(bit_b), .Clear_SI(clr),
    .Locked_SO(locked_b), .ErrPulse_SO(pulse_b), .ErrCnt_DO(err_b), .BitCnt_DO(bitc_b),
    .DbgState_DO(state_b)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mode 0: clean generator bits, 1: stream A forced to mispredict, 2: all zero
  task automatic step(input logic s_rst, input logic s_vld, input logic s_clr,
                      input int mode, input logic flip_b);
    logic nb_a, nb_b, pa, ba, bb;
    @(negedge clk);
    ba = 1'b0;
    bb = 1'b0;
    if (s_vld) begin
      nb_a = ^(g_a & TAPS_A);
      nb_b = ^(g_b & TAPS_B);
      g_a  = {g_a[9:0], nb_a};
      g_b  = {g_b[9:0], nb_b};
      pa   = ^(rx_a & TAPS_A);
      case (mode)
        1:       begin ba = ~pa;  bb = nb_b; end
        2:       begin ba = 1'b0; bb = 1'b0; end
        default: begin ba = nb_a; bb = nb_b; end
      endcase
      bb = bb ^ flip_b;
      if (!s_rst) rx_a = {rx_a[9:0], ba};
    end
    if (s_rst) rx_a = '0;
    rst   = s_rst;
    vld   = s_vld;
    clr   = s_clr;
    bit_a = ba;
    bit_b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic clean_bits(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int zero_bad, pulses_b, drops_b, nvalid, guard;
    logic v;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; vld = 1'b0; clr = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    g_a = 11'h001; g_b = 11'h001; rx_a = '0;

    // table rows: flipped B bit under Clear, its two tap echoes, gaps, reset
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 32'd0};
    for (int r = 3; r <= 10; r++)
      tbl[r] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'(r - 2)};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 32'd9};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 32'd10};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 32'd11};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 32'd11};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0};

    // reset, including reset winning over a coincident valid bit and clear
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 0, 1'b0);
    chk("reset_locked", locked_a, 0);
    chk("reset_pulse", pulse_a, 0);
    chk("reset_errcnt", err_a, 0);
    chk("reset_bitcnt", bitc_a, 0);
    chk("reset_state", state_a, prbs11_checker_pkg::ST_FILL);

    // all-zero stream never leaves FILL
    zero_bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 1'b0, 2, 1'b0);
      if (state_a != prbs11_checker_pkg::ST_FILL || locked_a) zero_bad++;
      if (state_b != prbs11_checker_pkg::ST_FILL || locked_b) zero_bad++;
    end
    chk("all_zero_stays_fill", zero_bad, 0);

    // 1000 clean bits from seed 1; B gets one flip at locked bit 100
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    g_a = 11'h001;
    g_b = 11'h001;
    pulses_b = 0;
    drops_b  = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(1'b0, 1'b1, 1'b0, 0, (i == 127));
      if (i == 26) chk("clean_not_locked_bit26", locked_a, 0);
      if (i == 27) begin
        chk("clean_locked_a_bit27", locked_a, 1);
        chk("clean_locked_b_bit27", locked_b, 1);
      end
      if (i >= 27) begin
        if (!locked_b) drops_b++;
        if (pulse_b) pulses_b++;
      end
    end
    chk("clean_errcnt_a", err_a, 0);
    chk("clean_bitcnt_a", bitc_a, 973);
    chk("flip_errcnt_b", err_b, 3);
    chk("flip_bitcnt_b", bitc_b, 973);
    chk("flip_pulses_b", pulses_b, 3);
    chk("flip_no_loss_b", drops_b, 0);

    // loss of lock on the 8th error, then relock after 27 clean bits
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    clean_bits(27);
    chk("loss_pre_locked", locked_a, 1);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1, 1'b0);
      if (i == 7) chk("loss_still_locked_7", locked_a, 1);
      if (i == 8) begin
        chk("loss_unlocked_8", locked_a, 0);
        chk("loss_pulse_8", pulse_a, 1);
        chk("loss_errcnt_8", err_a, 8);
        chk("loss_bitcnt_8", bitc_a, 8);
      end
    end
    chk("loss_errcnt_held", err_a, 8);
    chk("loss_bitcnt_held", bitc_a, 8);
    clean_bits(26);
    chk("relock_not_yet_26", locked_a, 0);
    clean_bits(1);
    chk("relock_at_27", locked_a, 1);
    chk("relock_b_undisturbed", locked_b, 1);

    // table-driven corner sequence from a fresh lock
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    clean_bits(27);
    for (int r = 0; r < 17; r++) begin
      step(tbl[r].rst, tbl[r].vld, tbl[r].clr, 0, tbl[r].flip_b);
      chk($sformatf("tbl%0d_locked_a", r), locked_a, tbl[r].exp_locked);
      chk($sformatf("tbl%0d_locked_b", r), locked_b, tbl[r].exp_locked);
      chk($sformatf("tbl%0d_pulse_b", r), pulse_b, tbl[r].exp_pulse_b);
      chk($sformatf("tbl%0d_errcnt_b", r), err_b, tbl[r].exp_err_b);
      chk($sformatf("tbl%0d_bitcnt_a", r), bitc_a, tbl[r].exp_bit_a);
      chk($sformatf("tbl%0d_errcnt_a", r), err_a, 0);
    end

    // random valid gaps do not disturb counting; reset mid-lock clears everything
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    nvalid = 0;
    guard  = 0;
    while (nvalid < 200 && guard < 2000) begin
      v = 1'($urandom_range(0, 1));
      step(1'b0, v, 1'b0, 0, 1'b0);
      if (v) nvalid++;
      guard++;
    end
    chk("gap_valid_bits_sent", nvalid, 200);
    chk("gap_locked_a", locked_a, 1);
    chk("gap_bitcnt_a", bitc_a, 173);
    chk("gap_bitcnt_b", bitc_b, 173);
    chk("gap_errcnt_a", err_a, 0);
    step(1'b1, 1'b1, 1'b1, 0, 1'b0);
    chk("midreset_locked_a", locked_a, 0);
    chk("midreset_locked_b", locked_b, 0);
    chk("midreset_pulse_a", pulse_a, 0);
    chk("midreset_errcnt_a", err_a, 0);
    chk("midreset_bitcnt_a", bitc_a, 0);
    chk("midreset_bitcnt_b", bitc_b, 0);
    chk("midreset_state_a", state_a, prbs11_checker_pkg::ST_FILL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs11_checker.md
PRBS11_CHECKER -- requirements
Module: prbs11_checker

Interface
REQ-001 Parameter DEGREE, default 11, SHALL set the LFSR degree and history register width.
REQ-002 Parameter TAPS, default package constant TAPS_DEG11, SHALL be the DEGREE-bit lag mask; bit k set means received lag k+1 feeds the prediction.
REQ-003 Parameter LOCK_CNT, default 16, SHALL set the consecutive correct predictions required to lock.
REQ-004 Parameter WINDOW, default 64, SHALL set the loss-detection window length in valid bits.
REQ-005 Parameter LOSS_THRESH, default 8, SHALL set the errors within one window that force loss of lock.
REQ-006 Port Clk_CI, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port Rst_RI, input, 1, SHALL be a synchronous, active-high reset.
REQ-008 Port BitValid_SI, input, 1, SHALL qualify Bit_DI; all state is held while low.
REQ-009 Port Bit_DI, input, 1, SHALL be the serial PRBS bit under test, typically the LFSR generator output.
REQ-010 Port Clear_SI, input, 1, SHALL zero ErrCnt_DO and BitCnt_DO without affecting lock state.
REQ-011 Port Locked_SO, output, 1, SHALL be high only in state LOCKED.
REQ-012 Port ErrPulse_SO, output, 1, SHALL pulse for one cycle per mismatched bit while LOCKED.
REQ-013 Port ErrCnt_DO, output, 16, SHALL be the saturating count of mismatched bits while LOCKED.
REQ-014 Port BitCnt_DO, output, 32, SHALL be the saturating count of valid bits checked while LOCKED.

Function
REQ-015 The history register SHALL shift in every valid bit, hist[0] newest, in every state (self-synchronising).
REQ-016 Predicted bit SHALL equal the XOR of hist[k] for all k with TAPS[k]=1, evaluated before the shift.
REQ-017 TAPS_DEG11 SHALL encode x^11+x^10+x^8+x^7+x^5+x^4+x^3+x+1: lags 1,3,4,6,7,8,10,11, i.e. 11'b11011101101.
REQ-018 States SHALL be FILL, VERIFY and LOCKED.
REQ-019 FILL SHALL count DEGREE valid bits, then go to VERIFY; if the resulting history is all-zero, it SHALL restart FILL.
REQ-020 VERIFY SHALL count consecutive matches and go to LOCKED on the LOCK_CNT-th match; any mismatch SHALL return it to FILL with counts cleared.
REQ-021 LOCKED SHALL count window bits and window errors; when window errors reach LOSS_THRESH it SHALL go to FILL; window counters SHALL clear after WINDOW bits.
REQ-022 Outputs SHALL be registered: Locked_SO, ErrPulse_SO and counter updates appear the cycle after the qualifying valid bit.
REQ-023 ErrCnt_DO SHALL hold at 16'hFFFF and BitCnt_DO at 32'hFFFFFFFF once saturated.
REQ-024 When Clear_SI coincides with a valid bit, the clear SHALL win, the counters SHALL read 0 next cycle, and ErrPulse_SO SHALL still assert if that bit mismatched.
REQ-025 Loss of lock SHALL leave ErrCnt_DO and BitCnt_DO unchanged; the error that triggers loss SHALL be counted and pulsed.

Reset
REQ-026 Reset SHALL set state FILL, history, fill/verify/window counters, ErrCnt_DO and BitCnt_DO to 0, and Locked_SO and ErrPulse_SO low.
REQ-027 Reset SHALL take priority over BitValid_SI and Clear_SI in the same cycle, and asserting it mid-lock SHALL drop Locked_SO the next cycle.

Structure
REQ-028 A shared package SHALL hold the state enum, TAPS_DEG11 and the counter widths (16, 32).
REQ-029 The tap-XOR predictor SHALL be a separate combinational sub-module, prbs_predict, parameterised by DEGREE and TAPS.

Verification
REQ-030 Clean stream: seed 11'h001, 1000 valid bits -> Locked_SO high after bit 27 (11+16), ErrCnt_DO=0, BitCnt_DO=973.
REQ-031 Single injected flip at locked bit 100 -> ErrCnt_DO=3 (self-sync propagation per tap-set hits), no lock loss, three ErrPulse_SO pulses.
REQ-032 All-zero input for 50 bits -> state stays FILL, Locked_SO low throughout.
REQ-033 After lock, 20 random bits -> Locked_SO falls on the 8th error; relock occurs after 27 clean bits.
REQ-034 Clear_SI coinciding with an injected error -> ErrCnt_DO=0 next cycle, ErrPulse_SO=1.
REQ-035 BitValid_SI toggled 50% randomly, plus Rst_RI mid-lock -> counts are unaffected by gaps, and all outputs are 0 the cycle after reset.
